// File: rtl/puf_pkg.sv
// Shared encodings for the PUF response read-back path.
// Main sequencer and UART byte transmitter state types.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        SEND,
        NEXT,
        FIN
    } main_state_e;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter with a registered tx line.
// tx_ready is high only when idle; a byte is taken on tx_valid && tx_ready.
module uart_tx_byte
    import puf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
    // The idle cycle after U_STOP is the final stop-bit cycle, so a
    // pending byte can start on the very next cycle.
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(CLKS_PER_BIT - 2);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        tx_ready = (state_q == U_IDLE);
        unique case (state_q)
            U_IDLE: begin
                if (tx_valid) begin
                    state_d = U_START;
                    cnt_d   = '0;
                    sh_d    = tx_data;
                    tx_d    = 1'b0;
                end
            end
            U_START: begin
                if (cnt_q == BIT_END) begin
                    state_d = U_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            U_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            U_STOP: begin
                if (cnt_q == STOP_END) begin
                    state_d = U_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = U_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx = tx_q;

endmodule

// File: rtl/puf_resp_uart_reader.sv
// Reads a range of PUF response words from RAM and streams them,
// LSB byte first, over a UART TX line to the host.
module puf_resp_uart_reader
    import puf_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int RD_LAT       = 1,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BPW = bytes_per_word(DATA_W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [1:0] LAT_END = 2'(RD_LAT - 1);

    main_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        lat_q, lat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_byte;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   words_dec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ram_addr_q <= '0;
            words_q    <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            lat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ram_addr_q <= ram_addr_d;
            words_q    <= words_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_byte = 8'(word_q >> {idx_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ram_addr_d = ram_addr_q;
        words_d    = words_q;
        word_d     = word_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ram_rden   = 1'b0;
        tx_valid   = 1'b0;
        addr_inc   = addr_q + 1'b1;
        words_dec  = words_q - 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    words_d = word_cnt;
                    busy_d  = 1'b1;
                    if (word_cnt == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d    = RD;
                        ram_addr_d = base_addr;
                    end
                end
            end
            RD: begin
                ram_rden = 1'b1;
                lat_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_END) begin
                    word_d  = ram_q;
                    idx_d   = '0;
                    state_d = SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = NEXT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            NEXT: begin
                addr_d  = addr_inc;
                words_d = words_dec;
                if (words_dec != '0) begin
                    state_d    = RD;
                    ram_addr_d = addr_inc;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // tx_ready doubles as "last stop bit finished".
                if (tx_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_byte),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx)
    );

    assign ram_addr = ram_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_puf_resp_uart_reader.sv
// Scoreboard bench: expected RAM addresses and UART bytes are queued
// at start and checked as the DUT reads RAM and emits frames.
module tb_puf_resp_uart_reader;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int RL    = 1;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_cnt;
    logic [AW-1:0] ram_addr;
    logic          ram_rden;
    logic [DW-1:0] ram_q;
    logic          tx;
    logic          busy;
    logic          done;

    puf_resp_uart_reader #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .RD_LAT(RL),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .word_cnt (word_cnt),
        .ram_addr (ram_addr),
        .ram_rden (ram_rden),
        .ram_q    (ram_q),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [32];
    always @(posedge clk) if (ram_rden) ram_q <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [7:0]    exp_bytes [$];
    logic [AW-1:0] exp_addrs [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    int   done_cnt = 0;
    int   done_cyc = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (ram_rden) begin
            if (exp_addrs.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", ram_addr, exp_addrs.pop_front());
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
            chk("busy_before_done", prev_busy, 1);
        end
        prev_busy = busy;
    end

    int   acc_cyc = 0;
    bit   dact = 0;
    int   dcnt = 0;
    int   prev_fs = 0;
    int   first_fs = 0;
    int   bidx = 0;
    int   cur_idx = 0;
    logic [7:0] dsh = '0;

    // Cycle-accurate 8N1 decoder: samples each bit in its middle.
    always @(negedge clk) begin
        if (!rst) begin
            dact = 0;
        end else if (!dact) begin
            if (tx === 1'b0) begin
                dact = 1;
                dcnt = 0;
                cur_idx = bidx;
                if (bidx == 0) begin
                    first_fs = cyc;
                    chk("start_latency", (cyc - acc_cyc) <= 3 + RL, 1);
                end else begin
                    chk("frame_gap", cyc - prev_fs, FRAME);
                end
                prev_fs = cyc;
                bidx++;
            end
        end else begin
            dcnt++;
            if (dcnt == 2) chk("start_bit", tx, 0);
            if (dcnt >= 6 && dcnt <= 34 && (dcnt - 6) % CPB == 0)
                dsh = {tx, dsh[7:1]};
            if (dcnt == 38) begin
                chk("stop_bit", tx, 1);
                if (exp_bytes.size() == 0) chk("byte_unexpected", 1, 0);
                else chk("byte", dsh, exp_bytes.pop_front());
            end
            if (dcnt == FRAME - 1) dact = 0;
        end
    end

    int d0 = 0;

    task automatic do_start(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            a = AW'(b + i);
            w = mem[a];
            exp_addrs.push_back(a);
            for (int k = 0; k < DW / 8; k++)
                exp_bytes.push_back(w[8*k +: 8]);
        end
        bidx = 0;
        d0 = done_cnt;
        start = 1'b1;
        base_addr = b;
        word_cnt = (AW+1)'(n);
        acc_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_txn(input int n, input string tag);
        int i = 0;
        while (done_cnt == d0 && i < n * 4 * FRAME + 200) begin
            @(negedge clk);
            i++;
        end
        if (done_cnt == d0) chk({tag, "_done_timeout"}, 0, 1);
        else chk({tag, "_done_time"}, done_cyc - first_fs, n * 4 * FRAME);
        repeat (5) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_bytes_left"}, exp_bytes.size(), 0);
        chk({tag, "_addrs_left"}, exp_addrs.size(), 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i;
        for (int j = 0; j < 32; j++)
            mem[j] = {8'(j), 8'hA0 ^ 8'(j), 8'(j * 3), 8'h5A};
        rst = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rden", ram_rden, 0);
        chk("rst_addr", ram_addr, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        mem[3] = 32'hA5C3_0F69;
        do_start(5'd3, 1);
        finish_txn(1, "single");

        mem[31] = 32'h0000_0001;
        mem[0]  = 32'h0000_0002;
        do_start(5'd31, 2);
        finish_txn(2, "wrap");

        do_start(5'd5, 0);
        chk("zero_busy_c1", busy, 1);
        chk("zero_done_c1", done, 0);
        @(negedge clk);
        chk("zero_done_c2", done, 1);
        chk("zero_busy_c2", busy, 0);
        @(negedge clk);
        chk("zero_done_c3", done, 0);
        repeat (3) @(negedge clk);
        chk("zero_done_count", done_cnt - d0, 1);
        chk("zero_tx", tx, 1);

        do_start(5'd3, 1);
        repeat (50) @(negedge clk);
        start = 1'b1;
        base_addr = 5'd31;
        word_cnt = 6'd2;
        @(negedge clk);
        start = 1'b0;
        finish_txn(1, "busy_start");

        do_start(5'd0, 1);
        i = 0;
        while (!(dact && cur_idx == 1 && dcnt == 17) && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("rst_mid_reached", dact && cur_idx == 1 && dcnt == 17, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rden", ram_rden, 0);
        exp_bytes.delete();
        exp_addrs.delete();
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mem[0] = 32'h8421_3CE7;
        do_start(5'd0, 1);
        finish_txn(1, "after_rst");

        do_start(5'd0, 32);
        finish_txn(32, "full");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
